piso8_tx: RTL

- Parallel-in/serial-out transmitter; the sending end of the serial bit stream consumed by the 8-bit multi-mode shift registers.
- Accepts a WIDTH-bit word over a valid/ready handshake and emits it one bit per clock on sOut, qualified by sValid.
- Bit order is selectable per word; mode_out carries the matching shift command for the receiving register.
- Supports a pause (stall) input and a synchronous abort (inz).

---
 rtl/piso8_tx.sv | 104 ++++++++++
 1 files changed

// File: rtl/piso8_tx.sv
// Parallel-in/serial-out transmitter: takes a WIDTH-bit word over valid/ready and
// emits it one bit per clock on sOut with a matching shift command on mode_out.
module piso8_tx #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned CW    = 3
) (
    input  logic             clk,
    input  logic             Re,
    input  logic             inz,
    input  logic [WIDTH-1:0] din,
    input  logic             din_valid,
    output logic             din_ready,
    input  logic             dir,
    input  logic             pause,
    output logic             sOut,
    output logic             sValid,
    output logic [1:0]       mode_out,
    output logic             busy,
    output logic             done
);

    typedef enum logic {
        StIdle,
        StShift
    } state_e;

    localparam logic [CW-1:0] LastCnt = CW'(WIDTH - 1);

    state_e           r_state, w_state_next;
    logic [WIDTH-1:0] r_sr, w_sr_next;
    logic [CW-1:0]    r_cnt, w_cnt_next;
    logic             r_dir, w_dir_next;
    logic             r_done, w_done_next;

    logic w_shift;
    logic w_step;
    logic w_load;

    assign w_shift = (r_state == StShift);
    assign w_step  = w_shift && !pause;
    assign w_load  = (r_state == StIdle) && din_valid && din_ready;

    // Re is also gated here so din_ready drops with the reset, not one edge later.
    assign din_ready = !Re && !inz && (r_state == StIdle);
    assign busy      = w_shift;
    assign sValid    = w_step;
    assign sOut      = w_shift ? (r_dir ? r_sr[WIDTH-1] : r_sr[0]) : 1'b0;
    assign mode_out  = w_step ? (r_dir ? 2'b10 : 2'b01) : 2'b00;
    assign done      = r_done;

    always_comb begin
        w_state_next = r_state;
        w_sr_next    = r_sr;
        w_cnt_next   = r_cnt;
        w_dir_next   = r_dir;
        w_done_next  = 1'b0;

        if (inz) begin
            w_state_next = StIdle;
            w_sr_next    = '0;
            w_cnt_next   = '0;
        end else begin
            unique case (r_state)
                StIdle: begin
                    if (w_load) begin
                        w_state_next = StShift;
                        w_sr_next    = din;
                        w_dir_next   = dir;
                        w_cnt_next   = '0;
                    end
                end
                StShift: begin
                    if (w_step) begin
                        // Shift toward the emitting end with zero fill.
                        w_sr_next  = r_dir ? {r_sr[WIDTH-2:0], 1'b0} : {1'b0, r_sr[WIDTH-1:1]};
                        w_cnt_next = r_cnt + CW'(1);
                        if (r_cnt == LastCnt) begin
                            w_state_next = StIdle;
                            w_done_next  = 1'b1;
                        end
                    end
                end
                default: w_state_next = StIdle;
            endcase
        end
    end

    always_ff @(posedge clk or posedge Re) begin
        if (Re) begin
            r_state <= StIdle;
            r_sr    <= '0;
            r_cnt   <= '0;
            r_dir   <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_sr    <= w_sr_next;
            r_cnt   <= w_cnt_next;
            r_dir   <= w_dir_next;
            r_done  <= w_done_next;
        end
    end

endmodule
